// File: rtl/wb_timer.sv
// wb_timer: two independent compare/auto-reload timers behind a Wishbone classic slave
module wb_timer #(
    parameter int unsigned prescale = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic [1:0]  intr
);
    logic [15:0]      psc_q, psc_d;
    logic             tick;
    logic             ack_q, ack_d, req;
    logic [31:0]      dat_q, dat_d, rd;
    logic [2:0]       a;
    logic [1:0]       en_q, en_d, ar_q, ar_d, ie_q, ie_d, fl_q, fl_d;
    logic [1:0][31:0] cmp_q, cmp_d, cnt_q, cnt_d;
    logic [1:0]       hit, wr_t, wr_c, wr_n;
    logic             unused_adr;

    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
    assign a          = wb_adr_i[4:2];
    assign req        = wb_stb_i & wb_cyc_i & ~ack_q;
    assign ack_d      = req;
    assign tick       = psc_q == 16'(prescale - 1);
    assign psc_d      = tick ? '0 : psc_q + 16'd1;
    assign dat_d      = req ? rd : dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign intr       = fl_q & ie_q;

    for (genvar g = 0; g < 2; g++) begin : g_t
        assign hit[g]  = tick & en_q[g] & (cnt_q[g] == cmp_q[g]);
        assign wr_t[g] = req & wb_we_i & (a == 3'(4 * g));
        assign wr_c[g] = req & wb_we_i & (a == 3'(4 * g + 1));
        assign wr_n[g] = req & wb_we_i & (a == 3'(4 * g + 2));
    end

    // read mux: timer select is a[2], register select is a[1:0]; index 3 reads zero
    always_comb begin
        rd = a[1:0] == 2'd0 ? {28'd0, fl_q[a[2]], ie_q[a[2]], ar_q[a[2]], en_q[a[2]]} :
             a[1:0] == 2'd1 ? cmp_q[a[2]] :
             a[1:0] == 2'd2 ? cnt_q[a[2]] : '0;
    end

    // timer next state: counting first, then bus writes override; a match always sets flag
    always_comb begin
        en_d  = en_q;
        ar_d  = ar_q;
        ie_d  = ie_q;
        fl_d  = fl_q;
        cmp_d = cmp_q;
        cnt_d = cnt_q;
        for (int n = 0; n < 2; n++) begin
            if (tick && en_q[n])
                cnt_d[n] = hit[n] ? (ar_q[n] ? '0 : cnt_q[n]) : cnt_q[n] + 32'd1;
            if (hit[n] && !ar_q[n])
                en_d[n] = 1'b0;
            if (wr_t[n] && wb_sel_i[0]) begin
                en_d[n] = wb_dat_i[0];
                ar_d[n] = wb_dat_i[1];
                ie_d[n] = wb_dat_i[2];
                if (wb_dat_i[3])
                    fl_d[n] = 1'b0;
            end
            if (hit[n])
                fl_d[n] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (wr_c[n] && wb_sel_i[b])
                    cmp_d[n][8*b +: 8] = wb_dat_i[8*b +: 8];
                if (wr_n[n] && wb_sel_i[b])
                    cnt_d[n][8*b +: 8] = wb_dat_i[8*b +: 8];
            end
        end
    end

    // state register; reset overrides every other update and aborts a pending ack
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            psc_q <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
            en_q  <= '0;
            ar_q  <= '0;
            ie_q  <= '0;
            fl_q  <= '0;
            cmp_q <= '0;
            cnt_q <= '0;
        end else begin
            psc_q <= psc_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            en_q  <= en_d;
            ar_q  <= ar_d;
            ie_q  <= ie_d;
            fl_q  <= fl_d;
            cmp_q <= cmp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: randomized scoreboard bench for wb_timer at prescale 1 and 4
module tb_wb_timer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0, we = 1'b0;
    logic [31:0] dat1, dat4;
    logic        ack1, ack4;
    logic [1:0]  intr1, intr4;
    int          checks = 0, errors = 0;

    typedef struct {bit rd; bit [31:0] v;} item_t;
    item_t q0[$], q1[$];

    int unsigned m_psc[2];
    bit          m_ack[2];
    bit          m_en[2][2], m_ar[2][2], m_ie[2][2], m_fl[2][2];
    bit [31:0]   m_cmp[2][2], m_cnt[2][2];

    wb_timer #(.prescale(1)) u1 (
        .clk(clk), .reset_n(reset_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat1),
        .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(stb), .wb_we_i(we), .wb_ack_o(ack1), .intr(intr1)
    );
    wb_timer #(.prescale(4)) u4 (
        .clk(clk), .reset_n(reset_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat4),
        .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(stb), .wb_we_i(we), .wb_ack_o(ack4), .intr(intr4)
    );

    always #5 clk = ~clk;

    function automatic int unsigned ps(int k);
        return k == 0 ? 1 : 4;
    endfunction

    function automatic bit [31:0] readval(int k, bit [2:0] a);
        int t;
        t = int'(a[2]);
        case (a[1:0])
            2'd0:    return {28'd0, m_fl[k][t], m_ie[k][t], m_ar[k][t], m_en[k][t]};
            2'd1:    return m_cmp[k][t];
            2'd2:    return m_cnt[k][t];
            default: return 32'd0;
        endcase
    endfunction

    // reference model: advances one clock edge of instance k given the bus inputs at that edge
    function automatic void step(int k, bit rst, bit s_stb, bit s_we, bit [2:0] a, bit [31:0] d, bit [3:0] s);
        bit        rq, tk, hit;
        bit [31:0] rv, nc, mask;
        item_t     it;
        if (rst) begin
            m_psc[k] = 0;
            m_ack[k] = 0;
            for (int t = 0; t < 2; t++) begin
                m_en[k][t] = 0; m_ar[k][t] = 0; m_ie[k][t] = 0; m_fl[k][t] = 0;
                m_cmp[k][t] = 0; m_cnt[k][t] = 0;
            end
            return;
        end
        rq   = s_stb && !m_ack[k];
        tk   = m_psc[k] == ps(k) - 1;
        rv   = readval(k, a);
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        for (int t = 0; t < 2; t++) begin
            hit = tk && m_en[k][t] && m_cnt[k][t] == m_cmp[k][t];
            nc  = m_cnt[k][t];
            if (tk && m_en[k][t] && !hit) nc = nc + 1;
            if (hit && m_ar[k][t]) nc = 0;
            if (hit && !m_ar[k][t]) m_en[k][t] = 0;
            if (rq && s_we && a == 3'(4 * t) && s[0]) begin
                m_en[k][t] = d[0];
                m_ar[k][t] = d[1];
                m_ie[k][t] = d[2];
                if (d[3]) m_fl[k][t] = 0;
            end
            if (hit) m_fl[k][t] = 1;
            if (rq && s_we && a == 3'(4 * t + 1)) m_cmp[k][t] = (m_cmp[k][t] & ~mask) | (d & mask);
            if (rq && s_we && a == 3'(4 * t + 2)) nc = (nc & ~mask) | (d & mask);
            m_cnt[k][t] = nc;
        end
        m_psc[k] = tk ? 0 : m_psc[k] + 1;
        m_ack[k] = rq;
        if (rq) begin
            it.rd = !s_we;
            it.v  = rv;
            if (k == 0) q0.push_back(it);
            else q1.push_back(it);
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(int k, logic a, logic [31:0] d, logic [1:0] ir);
        item_t it;
        chk($sformatf("ack%0d", k), 32'(a), 32'(m_ack[k]));
        chk($sformatf("intr%0d", k), 32'(ir),
            32'({m_fl[k][1] & m_ie[k][1], m_fl[k][0] & m_ie[k][0]}));
        if (a === 1'b1) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL sb%0d: got ack expected none pending", k);
            end else begin
                if (k == 0) it = q0.pop_front();
                else it = q1.pop_front();
                if (it.rd) chk($sformatf("rdata%0d", k), d, it.v);
            end
        end
    endtask

    // monitor: compares both instances against the model just after every rising edge
    initial forever begin
        @(posedge clk);
        #1;
        mon(0, ack1, dat1, intr1);
        mon(1, ack4, dat4, intr4);
    end

    task automatic cyc(bit rst, bit s_stb, bit s_we, bit [31:0] s_adr, bit [31:0] d, bit [3:0] s);
        @(negedge clk);
        reset_n = !rst;
        stb = s_stb;
        we  = s_we;
        adr = s_adr;
        dat = d;
        sel = s;
        for (int k = 0; k < 2; k++) step(k, rst, s_stb, s_we, s_adr[4:2], d, s);
        @(posedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic access(bit s_we, bit [2:0] a, bit [31:0] d, bit [3:0] s,
                          bit c = 0, bit [31:0] exp = 0, string nm = "");
        bit [31:0] ad;
        ad = {27'($urandom), a, 2'($urandom)};
        cyc(0, 1, s_we, ad, d, s);
        if (c) begin
            #1;
            chk(nm, dat1, exp);
        end
        cyc(0, 1, s_we, ad, d, s);
    endtask

    initial begin
        bit [2:0]  ra;
        bit [31:0] rdv;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 8; i++) access(0, 3'(i), 0, 0, 1, 0, "reset_read");
        access(1, 3'd2, 32'h12345678, 4'b0100);
        access(0, 3'd2, 0, 0, 1, 32'h00340000, "byte_sel");
        access(0, 3'd3, 0, 0, 1, 32'h0, "reserved");
        access(1, 3'd2, 0, 4'hf);
        access(1, 3'd1, 3, 4'hf);
        access(1, 3'd0, 7, 4'hf);
        idle(2);
        #1 chk("intr0_early", 32'(intr1[0]), 0);
        idle(1);
        #1 chk("intr0_rise", 32'(intr1[0]), 1);
        access(0, 3'd2, 0, 0, 1, 0, "ar_counter");
        access(1, 3'd0, 8, 4'hf);
        access(1, 3'd5, 5, 4'hf);
        access(1, 3'd4, 5, 4'hf);
        idle(10);
        access(0, 3'd6, 0, 0, 1, 5, "oneshot_cnt");
        access(0, 3'd4, 0, 0, 1, 32'h0c, "oneshot_tcr");
        #1 chk("intr1_set", 32'(intr1[1]), 1);
        access(1, 3'd4, 8, 4'hf);
        #1 chk("intr1_clr", 32'(intr1[1]), 0);
        access(0, 3'd4, 0, 0, 1, 0, "tcr1_clr");
        access(1, 3'd2, 0, 4'hf);
        access(1, 3'd0, 3, 4'hf);
        idle(2);
        access(1, 3'd0, 32'hb, 4'hf);
        access(0, 3'd0, 0, 0, 1, 32'hb, "w1c_vs_set");
        access(1, 3'd2, 32'haabbcc00, 4'hf);
        access(0, 3'd2, 0, 0, 1, 32'haabbcc01, "cnt_write_wins");
        access(1, 3'd0, 8, 4'hf);
        for (int i = 0; i < 600; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rdv = ra[1:0] == 2'd0 ? $urandom :
                  ($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 12));
            access(1'($urandom_range(0, 1)), ra, rdv,
                   $urandom_range(0, 1) == 1 ? 4'hf : 4'($urandom_range(0, 15)));
            idle($urandom_range(0, 3));
        end
        cyc(1, 1, 0, 32'h4, 0, 4'hf);
        #1 chk("rst_no_ack", 32'(ack1), 0);
        cyc(1, 1, 0, 32'h4, 0, 4'hf);
        cyc(0, 0, 0, 0, 0, 0);
        #1 chk("rst_release_ack", 32'(ack1), 0);
        for (int i = 0; i < 8; i++) access(0, 3'(i), 0, 0, 1, 0, "post_rst_read");
        idle(2);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter prescale, default 1, meaning: clock cycles per timer tick, legal range 1..65536.
REQ-002 clk  in  1  system clock; single clock domain, all state updates on rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low: sampled only on the rising edge of clk.
REQ-004 wb_adr_i  in  32  Wishbone address; only bits [4:2] decoded.
REQ-005 wb_dat_i  in  32  Wishbone write data.
REQ-006 wb_dat_o  out  32  Wishbone read data, registered.
REQ-007 wb_sel_i  in  4  byte selects; bit n enables byte n on writes.
REQ-008 wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone classic strobe, cycle and write enable.
REQ-009 wb_ack_o  out  1  Wishbone acknowledge, registered.
REQ-010 intr  out  2  per-timer interrupt, active-high level; intr[n] = flag_n & irqen_n.

Function
REQ-011 The register map, indexed by wb_adr_i[4:2], SHALL be: 0 TCR0, 1 COMPARE0, 2 COUNTER0, 3 reserved; 4 TCR1, 5 COMPARE1, 6 COUNTER1, 7 reserved.
REQ-012 TCRn bit layout SHALL be: [0] en, [1] ar (auto-reload), [2] irqen, [3] flag (read; write 1 clears, W1C); [31:4] read 0.
REQ-013 Reserved addresses SHALL read 0, ignore writes, and still acknowledge.
REQ-014 wb_ack_o SHALL assert exactly one cycle after a cycle with wb_stb_i & wb_cyc_i & ~wb_ack_o, for one cycle only; no back-to-back acks.
REQ-015 A write SHALL take effect on the same edge that raises wb_ack_o; read data SHALL be captured on that edge and hold while wb_ack_o is high.
REQ-016 COMPAREn and COUNTERn writes SHALL honour wb_sel_i per byte; TCRn writes SHALL use wb_sel_i[0] only.
REQ-017 The prescaler SHALL be a free-running counter from 0 to prescale-1, with tick asserted when it equals prescale-1; prescale=1 gives a tick every cycle.
REQ-018 On a tick with en=1 and COUNTERn != COMPAREn, COUNTERn SHALL increment by 1, wrapping modulo 2^32.
REQ-019 On a tick with en=1 and COUNTERn == COMPAREn:
- flag SHALL set.
- If ar=1, COUNTERn SHALL load 0 and en stays 1.
- If ar=0, en SHALL clear and COUNTERn SHALL hold at COMPAREn.
REQ-020 Auto-reload period SHALL be (COMPAREn+1)*prescale cycles.
REQ-021 While en=0, COUNTERn SHALL hold its value.
REQ-022 A bus write to COUNTERn on the same edge as an increment or reload SHALL win for the counter value; a match detected on that edge SHALL still set flag.
REQ-023 A W1C of flag on the same edge as a match SHALL leave flag set (set wins).
REQ-024 A TCR write to en with ar=0 on the same edge as a match SHALL leave en as written.
REQ-025 Timers 0 and 1 SHALL be fully independent and share only the prescaler tick.

Reset
REQ-026 When reset_n=0 at a clock edge, all of the following SHALL be 0 after that edge: TCR fields, COMPAREn, COUNTERn, prescaler, wb_ack_o, wb_dat_o and intr.
REQ-027 Reset asserted mid bus cycle SHALL abort the cycle with no ack; reset SHALL take priority over every other update.

Verification
REQ-028 prescale=1; COMPARE0=3; TCR0=0x7 -> intr[0] rises 4 cycles after the write edge; COUNTER0 reads 0; period 4 cycles.
REQ-029 prescale=1; COMPARE1=5; TCR1=0x5 (ar=0) -> COUNTER1 stops at 5; TCR1 reads 0x0C (en=0, flag=1, irqen=1); intr[1]=1; writing TCR1=0x8 clears flag and intr[1].
REQ-030 prescale=4; COMPARE0=1; TCR0=0x3 -> flag sets every 8 cycles; intr[0] stays 0 because irqen=0.
REQ-031 Write COUNTER0=0x12345678 with wb_sel_i=0b0100 over a counter of 0 -> reads 0x00340000; read of address 0x0C returns 0 with one-cycle ack.
REQ-032 W1C of flag coincident with a match -> flag reads 1; write to COUNTER coincident with an increment -> reads the written value.
REQ-033 Drive reset_n low during a held stb/cyc -> no ack; all registers read 0 after release.
